ddr_rx_deser: RTL and testbench
===============================

Name: ddr_rx_deser

Overview:
- DDR receive-side deserializer: the inverse of the team's SDR-to-DDR transmit path.
- Consumes the 2-bit per-clock output of an I_DDR capture primitive and finds word alignment using a sync pattern.
- After lock, assembles WORD_W-bit words and delivers them through a small valid/ready output FIFO to core logic.
- Sits directly behind the I_BUF_DS/I_DDR input pair on the clock-buffered domain.

Parameters:
- WORD_W, 8, output word width; even, at least 4.
- SYNC_PATTERN, 8'hA5, WORD_W-bit alignment pattern.
- LOCK_COUNT, 3, consecutive pattern words needed to declare lock; at least 1.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, at least 2.

Ports:
- clk_i  input  1  buffered receive clock.
- reset_n  input  1  synchronous, active-low reset.
- enable  input  1  capture enable; when low, no bits are consumed.
- ddr_data_i  input  2  I_DDR output; [0] is the rising-edge sample and the earlier bit, [1] is the falling-edge sample.
- resync_i  input  1  single-cycle pulse: drop lock and return to SEARCH.
- data_o  output  WORD_W  head-of-FIFO word.
- data_valid_o  output  1  data_o is valid.
- data_ready_i  input  1  consumer accepts data_o when valid and ready are both high.
- locked_o  output  1  alignment locked.
- overflow_o  output  1  sticky flag: a word was dropped because the FIFO was full.
- align_odd_o  output  1  alignment offset: 0 means words end on bit[1], 1 means words end on bit[0].

Behaviour:
- Clock and reset:
  - Single clock, clk_i. Reset is synchronous and active-low on reset_n.
  - Reset values: all outputs 0, data_o 0, FIFO empty, bit history cleared, state SEARCH.
  - Reset mid-word discards the partial word and all FIFO contents.
- Bit order: each enabled cycle, ddr_data_i[0] is shifted into history, then ddr_data_i[1]. Within a word, the earliest-received bit is the LSB.
- When enable is low: history, pair counter and state hold. FIFO pop still operates.
- State machine:
  - SEARCH, evaluated each enabled cycle after the shift:
    - W0 = last WORD_W bits ending at bit[1]. W1 = last WORD_W bits ending at bit[0] of the same cycle.
    - If W0 == SYNC_PATTERN: align_odd_o=0.
    - Else if W1 == SYNC_PATTERN: align_odd_o=1.
    - On either match: match count = 1, pair counter restarts at that boundary, go to VERIFY.
    - If LOCK_COUNT==1, go straight to LOCKED instead.
  - VERIFY, at each word boundary (every WORD_W/2 enabled cycles):
    - Word == SYNC_PATTERN: increment match count. Reaching LOCK_COUNT goes to LOCKED, with locked_o=1 from the next cycle.
    - Word != SYNC_PATTERN: go to SEARCH, match count = 0, locked_o stays 0.
    - Pattern words consumed during SEARCH and VERIFY are not delivered.
  - LOCKED: every completed word, including later SYNC_PATTERN words, is pushed into the FIFO. There is no automatic loss of lock.
  - resync_i in any state: next state SEARCH, locked_o=0, partial word discarded, FIFO contents kept. resync_i takes priority over a boundary in the same cycle.
- Latency: when a word completes in cycle N with the FIFO empty, data_o and data_valid_o update at the N+1 edge.
- FIFO:
  - Pop: data_valid_o && data_ready_i.
  - Push with FIFO full and no pop in the same cycle: the word is dropped and overflow_o is set, sticky until reset.
  - Push with FIFO full and a pop in the same cycle: push accepted, occupancy unchanged.
  - Push and pop when empty: illegal by construction, since valid is low.
  - data_o holds its value while data_valid_o && !data_ready_i.
- Pointer wrap-around is modulo FIFO_DEPTH, with an extra bit to distinguish full from empty.

Test Plan:
- Even-aligned lock: WORD_W=8, send A5 as ddr_data_i 01,01,10,10, three times, then 0x3C as 00,11,11,00 -> locked_o=1 after the third A5. Exactly one output word 0x3C, align_odd_o=0, data_valid_o one cycle after the last 0x3C pair.
- Odd alignment: prepend one junk bit (first pair 2'b10, then the stream shifted by one bit) -> lock with align_odd_o=1, output word 0x3C.
- VERIFY failure: send A5, A5, 0x00, then A5 x3, 0x5A -> no lock after the 0x00. Lock follows the later three A5 words; only 0x5A is output.
- Backpressure and overflow: hold data_ready_i=0, send 5 words after lock with FIFO_DEPTH=4 -> 4 words retained, overflow_o=1. Release ready -> first 4 words out in order, data_o stable while stalled.
- Enable gaps: deassert enable for 3 cycles between each pair of a post-lock word -> word assembled correctly; the gap cycles consume no bits.
- Reset mid-word, then resync: assert reset_n=0 for one cycle mid-word -> all outputs 0, state SEARCH. After relock, pulse resync_i -> locked_o=0 next cycle, FIFO words still drained.

Source files
------------

// File: rtl/ddr_rx_deser.sv
// DDR receive deserializer: finds word alignment on an I_DDR bit-pair stream via a
// sync pattern, then assembles words into a small valid/ready output FIFO.
module ddr_rx_deser #(
  parameter int unsigned        WORD_W       = 8,
  parameter logic [WORD_W-1:0]  SYNC_PATTERN = WORD_W'(8'hA5),
  parameter int unsigned        LOCK_COUNT   = 3,
  parameter int unsigned        FIFO_DEPTH   = 4
) (
  input  logic              clk_i,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [1:0]        ddr_data_i,
  input  logic              resync_i,
  output logic [WORD_W-1:0] data_o,
  output logic              data_valid_o,
  input  logic              data_ready_i,
  output logic              locked_o,
  output logic              overflow_o,
  output logic              align_odd_o
);

  localparam int unsigned HALF   = WORD_W / 2;
  localparam int unsigned PAIR_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned CNT_W  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned PW1    = PTR_W + 1;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]        state_q, state_nxt;
  logic [WORD_W-2:0] hist_q;
  logic [WORD_W-1:0] w0, w1, word;
  logic [PAIR_W-1:0] pair_q, pair_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              odd_nxt;
  logic              boundary;
  logic              push;

  // Newest bit sits at the MSB, so the earliest-received bit lands in the word LSB.
  assign w0       = {ddr_data_i[1], ddr_data_i[0], hist_q[WORD_W-2:1]};
  assign w1       = {ddr_data_i[0], hist_q};
  assign word     = align_odd_o ? w1 : w0;
  assign boundary = enable && (pair_q == PAIR_W'(HALF - 1));

  // Alignment state register and bit history.
  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      state_q     <= ST_SEARCH;
      hist_q      <= '0;
      pair_q      <= '0;
      cnt_q       <= '0;
      align_odd_o <= 1'b0;
      locked_o    <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      pair_q      <= pair_nxt;
      cnt_q       <= cnt_nxt;
      align_odd_o <= odd_nxt;
      locked_o    <= (state_nxt == ST_LOCKED);
      if (enable) hist_q <= w0[WORD_W-1:1];
    end
  end

  // Next-state, pair counting and push decision.
  always_comb begin
    state_nxt = state_q;
    pair_nxt  = pair_q;
    cnt_nxt   = cnt_q;
    odd_nxt   = align_odd_o;
    push      = 1'b0;
    if (resync_i) begin
      state_nxt = ST_SEARCH;
      pair_nxt  = '0;
      cnt_nxt   = '0;
    end else if (enable) begin
      pair_nxt = boundary ? '0 : PAIR_W'(pair_q + 1'b1);
      case (state_q)
        ST_SEARCH: begin
          if ((w0 == SYNC_PATTERN) || (w1 == SYNC_PATTERN)) begin
            odd_nxt   = (w0 != SYNC_PATTERN);
            pair_nxt  = '0;
            cnt_nxt   = CNT_W'(1);
            state_nxt = (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (boundary) begin
            if (word == SYNC_PATTERN) begin
              cnt_nxt = CNT_W'(cnt_q + 1'b1);
              if (cnt_q == CNT_W'(LOCK_COUNT - 1)) state_nxt = ST_LOCKED;
            end else begin
              cnt_nxt   = '0;
              state_nxt = ST_SEARCH;
            end
          end
        end
        ST_LOCKED: push = boundary;
        default:   state_nxt = ST_SEARCH;
      endcase
    end
  end

  // Output FIFO; data_o is a registered copy of the head entry.
  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW1-1:0]    wr_q, rd_q, wr_nxt, rd_nxt;
  logic [WORD_W-1:0] head_nxt;
  logic              pop, full, push_ok, drop, empty_nxt;

  assign pop       = data_valid_o && data_ready_i;
  assign full      = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                     (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign push_ok   = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign wr_nxt    = wr_q + PW1'(push_ok);
  assign rd_nxt    = rd_q + PW1'(pop);
  assign empty_nxt = (wr_nxt == rd_nxt);
  assign head_nxt  = (push_ok && (rd_nxt[PTR_W-1:0] == wr_q[PTR_W-1:0])) ?
                     word : mem_q[rd_nxt[PTR_W-1:0]];

  always_ff @(posedge clk_i) begin
    if (reset_n && push_ok) mem_q[wr_q[PTR_W-1:0]] <= word;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      wr_q         <= '0;
      rd_q         <= '0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      wr_q         <= wr_nxt;
      rd_q         <= rd_nxt;
      data_valid_o <= !empty_nxt;
      if (!empty_nxt) data_o <= head_nxt;
      if (drop) overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr_rx_deser.sv
// Scoreboard bench for ddr_rx_deser: directed bit-pair streams, expected words queued
// at stimulus time and compared by a decoupled monitor on each output handshake.
module tb_ddr_rx_deser;

  logic       clk_i = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [1:0] ddr_data_i;
  logic       resync_i;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       data_ready_i;
  logic       locked_o;
  logic       overflow_o;
  logic       align_odd_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  bit         bq[$];

  ddr_rx_deser #(
    .WORD_W(8), .SYNC_PATTERN(8'hA5), .LOCK_COUNT(3), .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk_i), .reset_n(reset_n), .enable(enable), .ddr_data_i(ddr_data_i),
    .resync_i(resync_i), .data_o(data_o), .data_valid_o(data_valid_o),
    .data_ready_i(data_ready_i), .locked_o(locked_o), .overflow_o(overflow_o),
    .align_odd_o(align_odd_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; enable = 1'b0; resync_i = 1'b0; ddr_data_i = 2'b00;
    tick();
    exp_q.delete();
    reset_n = 1'b1;
  endtask

  task automatic send_pair(input logic [1:0] p);
    enable = 1'b1; ddr_data_i = p;
    tick();
    enable = 1'b0; ddr_data_i = 2'b00;
  endtask

  task automatic send_pairs(input logic [7:0] w, input int first, input int last);
    for (int i = first; i <= last; i++) send_pair({w[2*i+1], w[2*i]});
  endtask

  task automatic send_word(input logic [7:0] w);
    send_pairs(w, 0, 3);
  endtask

  task automatic lock_up();
    for (int i = 0; i < 3; i++) send_word(8'hA5);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " data_o"},       32'(data_o),       32'h0);
    check({tag, " data_valid_o"}, 32'(data_valid_o), 32'h0);
    check({tag, " locked_o"},     32'(locked_o),     32'h0);
    check({tag, " overflow_o"},   32'(overflow_o),   32'h0);
    check({tag, " align_odd_o"},  32'(align_odd_o),  32'h0);
  endtask

  // Monitor: at the falling edge, inputs and outputs are what the next edge will see.
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk_i);
      if (reset_n && data_valid_o && data_ready_i) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra: got 0x%02h, expected no word", data_o);
        end else begin
          e = exp_q.pop_front();
          if (data_o !== e) begin
            n_fail++;
            $display("FAIL sb_word: got 0x%02h, expected 0x%02h", data_o, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; resync_i = 1'b0;
    ddr_data_i = 2'b00; data_ready_i = 1'b1;

    // Even-aligned lock
    do_reset();
    check_reset_outputs("rst");
    send_word(8'hA5); send_word(8'hA5);
    send_pairs(8'hA5, 0, 2);
    check("even locked_early", 32'(locked_o), 32'h0);
    send_pairs(8'hA5, 3, 3);
    check("even locked", 32'(locked_o), 32'h1);
    exp_q.push_back(8'h3C);
    send_pair(2'b00); send_pair(2'b11); send_pair(2'b11);
    check("even valid_early", 32'(data_valid_o), 32'h0);
    send_pair(2'b00);
    check("even valid", 32'(data_valid_o), 32'h1);
    check("even data", 32'(data_o), 32'h3C);
    check("even align", 32'(align_odd_o), 32'h0);
    idle(3);
    check("even drained", 32'(data_valid_o), 32'h0);

    // Odd alignment: one junk bit ahead, one pad bit behind
    do_reset();
    bq.push_back(1'b0);
    for (int k = 0; k < 3; k++) for (int i = 0; i < 8; i++) bq.push_back(bit'(8'hA5 >> i));
    for (int i = 0; i < 8; i++) bq.push_back(bit'(8'h3C >> i));
    bq.push_back(1'b0);
    check("odd first_pair", 32'({bq[1], bq[0]}), 32'h2);
    exp_q.push_back(8'h3C);
    while (bq.size() >= 2) begin
      logic b0, b1;
      b0 = bq.pop_front(); b1 = bq.pop_front();
      send_pair({b1, b0});
    end
    check("odd locked", 32'(locked_o), 32'h1);
    check("odd align", 32'(align_odd_o), 32'h1);
    check("odd valid", 32'(data_valid_o), 32'h1);
    idle(3);

    // VERIFY failure then later lock
    do_reset();
    send_word(8'hA5); send_word(8'hA5); send_word(8'h00);
    check("vfail locked", 32'(locked_o), 32'h0);
    lock_up();
    check("vfail relock", 32'(locked_o), 32'h1);
    exp_q.push_back(8'h5A);
    send_word(8'h5A);
    idle(3);

    // Backpressure and overflow
    do_reset();
    lock_up();
    data_ready_i = 1'b0;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44);
    check("bp no_overflow", 32'(overflow_o), 32'h0);
    send_word(8'h55);
    check("bp overflow", 32'(overflow_o), 32'h1);
    check("bp head", 32'(data_o), 32'h11);
    idle(3);
    check("bp stable", 32'(data_o), 32'h11);
    check("bp valid", 32'(data_valid_o), 32'h1);
    data_ready_i = 1'b1;
    idle(6);
    check("bp empty", 32'(data_valid_o), 32'h0);
    check("bp sticky", 32'(overflow_o), 32'h1);

    // Enable gaps between pairs
    do_reset();
    lock_up();
    exp_q.push_back(8'h96);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] w;
      w = 8'h96;
      send_pair({w[2*i+1], w[2*i]});
      if (i < 3) begin
        ddr_data_i = 2'b11;
        idle(3);
        ddr_data_i = 2'b00;
      end
    end
    check("gap valid", 32'(data_valid_o), 32'h1);
    check("gap data", 32'(data_o), 32'h96);
    exp_q.push_back(8'h0F);
    send_word(8'h0F);
    idle(3);

    // Reset mid-word, relock, then resync keeps FIFO contents
    do_reset();
    lock_up();
    data_ready_i = 1'b0;
    send_word(8'h77);
    send_pairs(8'h5A, 0, 1);
    reset_n = 1'b0;
    tick();
    exp_q.delete();
    reset_n = 1'b1;
    check_reset_outputs("midrst");
    lock_up();
    check("rs locked", 32'(locked_o), 32'h1);
    exp_q.push_back(8'hC3); exp_q.push_back(8'h81);
    send_word(8'hC3); send_word(8'h81);
    resync_i = 1'b1;
    tick();
    resync_i = 1'b0;
    check("rs unlocked", 32'(locked_o), 32'h0);
    check("rs kept", 32'(data_valid_o), 32'h1);
    check("rs head", 32'(data_o), 32'hC3);
    send_word(8'h12);
    data_ready_i = 1'b1;
    idle(6);
    check("rs drained", 32'(data_valid_o), 32'h0);

    check("sb leftover", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
